// File: rtl/apb_periph_pkg.sv
// Shared definitions for APB peripherals on the bridge bus: register
// offsets, CTRL/STATUS bit positions, APB FSM states and the response type.
package apb_periph_pkg;

    // Byte offsets inside the 32-byte peripheral window (paddr[4:0], word aligned)
    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_STATUS = 5'h04;
    localparam logic [4:0] REG_DATA   = 5'h08;
    localparam logic [4:0] REG_ID     = 5'h0C;
    localparam logic [4:0] REG_THRESH = 5'h10;

    // CTRL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    // STATUS bit positions
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_UDF_BIT   = 3;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } apb_state_t;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

    localparam apb_resp_t RESP_NONE = '{prdata: 32'h0000_0000, pslverr: 1'b0};

endpackage

// File: rtl/sample_sync_fifo.sv
// Single-clock sample FIFO. The head entry is presented combinationally on
// dout while the FIFO is not empty, so a pop in the same cycle returns it.
// A flush empties the FIFO and overrides any push/pop in the same cycle.
// A push while full is only accepted when a pop happens in the same cycle.
module sample_sync_fifo #(
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 64
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [SAMPLE_W-1:0]      din,
    output logic [SAMPLE_W-1:0]      dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [SAMPLE_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         level_r;
    logic                push_ok_s;
    logic                pop_ok_s;

    assign full     = (level_r == LVL_FULL);
    assign empty    = (level_r == LVL_ZERO);
    assign level    = level_r;
    assign dout     = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~flush & ~empty;
    assign push_ok_s = push & ~flush & (~full | pop_ok_s);

    // Sample storage: write the accepted sample at the write pointer
    always_ff @(posedge sys_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; reset and flush both empty the FIFO
    always_ff @(posedge sys_clk) begin
        if (rst || flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/apb_sample_fifo.sv
// APB slave buffering GNSS front-end samples. Registers: CTRL, STATUS,
// DATA (pop on read), ID. Every transfer gets exactly one wait state; all
// side effects take place on the edge that latches the transfer, and the
// response is presented from registers on the following cycle.
// Optional feature macro FIFO_THRESH_IRQ_EN adds the THRESH register,
// CTRL.IRQ_EN and a registered FIFO-level interrupt; otherwise irq is 0.
module apb_sample_fifo
    import apb_periph_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h5000,
    parameter int          SAMPLE_W  = 8,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] ID_VALUE  = 32'h5346_0001
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [15:0]         apb_paddr,
    input  logic                apb_pwrite,
    input  logic                apb_psel,
    input  logic                apb_penable,
    input  logic [3:0]          apb_pstrb,
    input  logic [31:0]         apb_pwdata,
    output logic [31:0]         apb_prdata,
    output logic                apb_pready,
    output logic                apb_pslverr,
    output logic                irq
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [SAMPLE_W-1:0] fifo_dout_s;
    logic [LVL_W-1:0]    fifo_level_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    apb_state_t          state_r;
    logic [31:0]         apb_prdata_r;
    logic                apb_pready_r;
    logic                apb_pslverr_r;
    logic                ctrl_en_r;
    logic                ovf_r;
    logic                udf_r;

    logic                hit_s;
    logic                access_s;
    logic                wr_acc_s;
    logic                rd_acc_s;
    logic [4:0]          offset_s;
    logic                ctrl_wr_s;
    logic                stat_wr_s;
    logic                data_rd_s;
    logic                flush_s;
    logic                pop_s;
    logic                push_req_s;
    logic                push_s;
    logic                ovf_set_s;
    logic                udf_set_s;
    logic [7:0]          lvl8_s;
    logic [31:0]         ctrl_rd_s;
    logic [31:0]         status_rd_s;
    apb_resp_t           resp_s;
    logic                unused_s;

`ifdef FIFO_THRESH_IRQ_EN
    logic                ctrl_irq_en_r;
    logic [7:0]          thresh_r;
    logic                irq_r;
    logic                thresh_wr_s;
`endif

    // Address window decode and transfer qualification
    assign hit_s    = (apb_paddr[15:5] == BASE_ADDR[15:5]);
    assign offset_s = {apb_paddr[4:2], 2'b00};
    assign access_s = (state_r == ST_IDLE) & apb_psel & apb_penable & ~apb_pready_r & hit_s;
    assign wr_acc_s = access_s & apb_pwrite;
    assign rd_acc_s = access_s & ~apb_pwrite;

    // Write-data, strobe and address bits outside the decoded fields carry no meaning here
    assign unused_s = ^{apb_paddr[1:0], apb_pwdata[31:4], apb_pstrb[3:1]};

    // FIFO control: flush beats a coincident push; a full FIFO only takes a push alongside a pop
    assign flush_s    = ctrl_wr_s & apb_pstrb[0] & apb_pwdata[CTRL_FLUSH_BIT];
    assign pop_s      = data_rd_s & ~fifo_empty_s;
    assign push_req_s = sample_valid & ctrl_en_r & ~flush_s;
    assign push_s     = push_req_s & (~fifo_full_s | pop_s);
    assign ovf_set_s  = push_req_s & fifo_full_s & ~pop_s;
    assign udf_set_s  = data_rd_s & fifo_empty_s;
    assign lvl8_s     = 8'(fifo_level_s);

    sample_sync_fifo #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .din     (sample_data),
        .dout    (fifo_dout_s),
        .level   (fifo_level_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // CTRL and STATUS read images (FLUSH always reads back as 0)
    always_comb begin
        ctrl_rd_s                    = 32'h0000_0000;
        ctrl_rd_s[CTRL_EN_BIT]       = ctrl_en_r;
`ifdef FIFO_THRESH_IRQ_EN
        ctrl_rd_s[CTRL_IRQ_EN_BIT]   = ctrl_irq_en_r;
`endif
        status_rd_s                  = 32'h0000_0000;
        status_rd_s[STAT_EMPTY_BIT]  = fifo_empty_s;
        status_rd_s[STAT_FULL_BIT]   = fifo_full_s;
        status_rd_s[STAT_OVF_BIT]    = ovf_r;
        status_rd_s[STAT_UDF_BIT]    = udf_r;
        status_rd_s[STAT_LEVEL_LSB +: 8] = lvl8_s;
    end

    // Register decode: read data, error response and per-register strobes
    always_comb begin
        resp_s    = RESP_NONE;
        ctrl_wr_s = 1'b0;
        stat_wr_s = 1'b0;
        data_rd_s = 1'b0;
`ifdef FIFO_THRESH_IRQ_EN
        thresh_wr_s = 1'b0;
`endif
        case (offset_s)
            REG_CTRL: begin
                resp_s.prdata = ctrl_rd_s;
                ctrl_wr_s     = wr_acc_s;
            end
            REG_STATUS: begin
                resp_s.prdata = status_rd_s;
                stat_wr_s     = wr_acc_s;
            end
            REG_DATA: begin
                if (apb_pwrite) begin
                    resp_s.pslverr = 1'b1;
                end else if (fifo_empty_s) begin
                    resp_s.prdata = 32'h0000_0000;
                end else begin
                    resp_s.prdata = 32'(fifo_dout_s);
                end
                data_rd_s = rd_acc_s;
            end
            REG_ID: begin
                if (apb_pwrite) begin
                    resp_s.pslverr = 1'b1;
                end else begin
                    resp_s.prdata = ID_VALUE;
                end
            end
`ifdef FIFO_THRESH_IRQ_EN
            REG_THRESH: begin
                resp_s.prdata = {24'h00_0000, thresh_r};
                thresh_wr_s   = wr_acc_s;
            end
`endif
            default: begin
                resp_s.pslverr = apb_pwrite;
            end
        endcase
    end

    // APB response FSM: latch a transfer in IDLE, present it for one cycle in RESP
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            apb_pready_r  <= 1'b0;
            apb_prdata_r  <= 32'h0000_0000;
            apb_pslverr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        state_r       <= ST_RESP;
                        apb_pready_r  <= 1'b1;
                        apb_prdata_r  <= apb_pwrite ? 32'h0000_0000 : resp_s.prdata;
                        apb_pslverr_r <= resp_s.pslverr;
                    end else begin
                        state_r       <= ST_IDLE;
                        apb_pready_r  <= 1'b0;
                        apb_prdata_r  <= 32'h0000_0000;
                        apb_pslverr_r <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_r       <= ST_IDLE;
                    apb_pready_r  <= 1'b0;
                    apb_prdata_r  <= 32'h0000_0000;
                    apb_pslverr_r <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    apb_pready_r  <= 1'b0;
                    apb_prdata_r  <= 32'h0000_0000;
                    apb_pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    // CTRL register; only byte lane 0 carries control bits
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ctrl_en_r <= 1'b0;
        end else if (ctrl_wr_s && apb_pstrb[0]) begin
            ctrl_en_r <= apb_pwdata[CTRL_EN_BIT];
        end
    end

    // Sticky overflow/underflow flags; a new event wins over a same-cycle W1C
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (stat_wr_s && apb_pstrb[0] && apb_pwdata[STAT_OVF_BIT]) begin
                ovf_r <= 1'b0;
            end
            if (udf_set_s) begin
                udf_r <= 1'b1;
            end else if (stat_wr_s && apb_pstrb[0] && apb_pwdata[STAT_UDF_BIT]) begin
                udf_r <= 1'b0;
            end
        end
    end

`ifdef FIFO_THRESH_IRQ_EN
    // IRQ enable, threshold register and registered level-threshold interrupt
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ctrl_irq_en_r <= 1'b0;
            thresh_r      <= 8'h00;
            irq_r         <= 1'b0;
        end else begin
            if (ctrl_wr_s && apb_pstrb[0]) begin
                ctrl_irq_en_r <= apb_pwdata[CTRL_IRQ_EN_BIT];
            end
            if (thresh_wr_s && apb_pstrb[0]) begin
                thresh_r <= apb_pwdata[7:0];
            end
            irq_r <= ctrl_irq_en_r && (32'(fifo_level_s) >= 32'(thresh_r)) && (thresh_r != 8'h00);
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    assign apb_prdata  = apb_prdata_r;
    assign apb_pready  = apb_pready_r;
    assign apb_pslverr = apb_pslverr_r;

endmodule

// File: tb/tb_apb_sample_fifo.sv
// Scoreboard bench for apb_sample_fifo: each APB transfer pushes its
// expected response into a queue; a monitor pops and compares whenever the
// DUT raises pready. Stimulus is a directed sequence with hand-computed values.
module tb_apb_sample_fifo;

    localparam logic [15:0] BASE = 16'h5000;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_data = 8'h00;
    logic [15:0] apb_paddr = 16'h0000;
    logic        apb_pwrite = 1'b0;
    logic        apb_psel = 1'b0;
    logic        apb_penable = 1'b0;
    logic [3:0]  apb_pstrb = 4'h0;
    logic [31:0] apb_pwdata = 32'h0;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;
    logic        irq;

    typedef struct {
        logic [31:0] d;
        logic        chk_d;
        logic        e;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    apb_sample_fifo #(
        .BASE_ADDR (16'h5000),
        .SAMPLE_W  (8),
        .DEPTH     (64),
        .ID_VALUE  (32'h5346_0001)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .apb_paddr    (apb_paddr),
        .apb_pwrite   (apb_pwrite),
        .apb_psel     (apb_psel),
        .apb_penable  (apb_penable),
        .apb_pstrb    (apb_pstrb),
        .apb_pwdata   (apb_pwdata),
        .apb_prdata   (apb_prdata),
        .apb_pready   (apb_pready),
        .apb_pslverr  (apb_pslverr),
        .irq          (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every pready pulse consumes one expected response
    always @(negedge sys_clk) begin
        if (!rst && apb_pready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk_d) chk({mon_e.nm, "_data"}, apb_prdata, mon_e.d);
                chk({mon_e.nm, "_err"}, 32'(apb_pslverr), 32'(mon_e.e));
            end
        end
    end

    task automatic apb_xfer(input logic [4:0] off, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic with_s, input logic [7:0] sdat,
                            input logic [31:0] exp_d, input logic chk_d, input logic exp_e,
                            input string nm);
        int n;
        exp_q.push_back('{d: exp_d, chk_d: chk_d, e: exp_e, nm: nm});
        @(negedge sys_clk);
        apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = BASE + 16'(off);
        apb_pwrite = wr; apb_pwdata = wdata; apb_pstrb = strb;
        @(negedge sys_clk);
        apb_penable = 1'b1;
        if (with_s) begin
            sample_valid = 1'b1; sample_data = sdat;
        end
        @(negedge sys_clk);
        sample_valid = 1'b0;
        chk({nm, "_latency"}, 32'(apb_pready), 32'd1);
        n = 0;
        while (!apb_pready && n < 6) begin
            @(negedge sys_clk);
            n++;
        end
        if (!apb_pready) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_back());
        end
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        @(negedge sys_clk);
        chk({nm, "_pready_drop"}, 32'(apb_pready), 32'd0);
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] exp_d, input string nm);
        apb_xfer(off, 1'b0, 32'h0, 4'h0, 1'b0, 8'h00, exp_d, 1'b1, 1'b0, nm);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] wd, input logic [3:0] strb,
                      input logic exp_e, input string nm);
        apb_xfer(off, 1'b1, wd, strb, 1'b0, 8'h00, 32'h0, 1'b0, exp_e, nm);
    endtask

    task automatic push_run(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            sample_valid = 1'b1;
            sample_data = base + 8'(i);
        end
        @(negedge sys_clk);
        sample_valid = 1'b0;
    endtask

    // Transfers outside the window or without psel must never get pready
    task automatic ignored_xfer(input logic [15:0] addr, input logic sel, input string nm);
        int seen;
        seen = 0;
        @(negedge sys_clk);
        apb_psel = sel; apb_penable = 1'b0; apb_paddr = addr; apb_pwrite = 1'b0;
        @(negedge sys_clk);
        apb_penable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            if (apb_pready) seen++;
        end
        apb_psel = 1'b0; apb_penable = 1'b0;
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_pready", 32'(apb_pready), 32'd0);
        chk("rst_prdata", apb_prdata, 32'd0);
        chk("rst_pslverr", 32'(apb_pslverr), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        // ID and reset STATUS
        rd(5'h0C, 32'h5346_0001, "id");
        rd(5'h04, 32'h0000_0001, "status_reset");

        // Basic capture and drain
        wr(5'h00, 32'h1, 4'hF, 1'b0, "ctrl_en");
        push_run(8'hA1, 3);
        rd(5'h04, 32'h0000_0300, "status_lvl3");
        rd(5'h08, 32'h0000_00A1, "data_a1");
        rd(5'h08, 32'h0000_00A2, "data_a2");
        rd(5'h08, 32'h0000_00A3, "data_a3");
        rd(5'h04, 32'h0000_0001, "status_drained");

        // Fill past full: overflow, W1C, ordering, pop+push while full
        push_run(8'hC0, 66);
        rd(5'h04, 32'h0000_4006, "status_full_ovf");
        wr(5'h04, 32'h4, 4'hF, 1'b0, "w1c_ovf");
        rd(5'h04, 32'h0000_4002, "status_ovf_clr");
        rd(5'h08, 32'h0000_00C0, "data_first");
        rd(5'h04, 32'h0000_3F00, "status_lvl63");
        push_run(8'hEE, 1);
        apb_xfer(5'h08, 1'b0, 32'h0, 4'h0, 1'b1, 8'h55, 32'h0000_00C1, 1'b1, 1'b0, "data_pop_push_full");
        rd(5'h04, 32'h0000_4002, "status_full_kept");

        // Flush, underflow and error responses
        wr(5'h00, 32'h3, 4'hF, 1'b0, "ctrl_flush");
        rd(5'h00, 32'h0000_0001, "ctrl_after_flush");
        rd(5'h04, 32'h0000_0001, "status_flushed");
        rd(5'h08, 32'h0000_0000, "data_empty");
        rd(5'h04, 32'h0000_0009, "status_udf");
        wr(5'h08, 32'h1234, 4'hF, 1'b1, "wr_data_err");
        wr(5'h0C, 32'h1234, 4'hF, 1'b1, "wr_id_err");
        wr(5'h18, 32'h1234, 4'hF, 1'b1, "wr_unused_err");
        rd(5'h18, 32'h0000_0000, "rd_unused");
        rd(5'h04, 32'h0000_0009, "status_no_change");

        // Push and DATA read on an empty FIFO in the same cycle
        wr(5'h04, 32'h8, 4'hF, 1'b0, "w1c_udf");
        rd(5'h04, 32'h0000_0001, "status_udf_clr");
        apb_xfer(5'h08, 1'b0, 32'h0, 4'h0, 1'b1, 8'h77, 32'h0000_0000, 1'b1, 1'b0, "data_empty_push");
        rd(5'h04, 32'h0000_0108, "status_push_kept");
        rd(5'h08, 32'h0000_0077, "data_77");
        rd(5'h04, 32'h0000_0009, "status_empty_udf");

        // Flush coincident with a sample at LEVEL=5
        push_run(8'h01, 5);
        rd(5'h04, 32'h0000_0508, "status_lvl5");
        apb_xfer(5'h00, 1'b1, 32'h3, 4'hF, 1'b1, 8'h99, 32'h0, 1'b0, 1'b0, "flush_with_sample");
        rd(5'h04, 32'h0000_0009, "status_flush_wins");

        // Capture disabled and byte-strobe handling
        wr(5'h00, 32'h0, 4'hF, 1'b0, "ctrl_dis");
        push_run(8'h42, 1);
        rd(5'h04, 32'h0000_0009, "status_en0_drop");
        rd(5'h00, 32'h0000_0000, "ctrl_zero");
        wr(5'h00, 32'h1, 4'hE, 1'b0, "ctrl_nostrb");
        rd(5'h00, 32'h0000_0000, "ctrl_strb_ignored");
        push_run(8'h43, 1);
        rd(5'h04, 32'h0000_0009, "status_still_empty");

        // Ignored transfers
        ignored_xfer(16'h6004, 1'b1, "out_of_window");
        ignored_xfer(BASE + 16'h0004, 1'b0, "no_psel");

`ifdef FIFO_THRESH_IRQ_EN
        // Threshold interrupt
        wr(5'h10, 32'h4, 4'hF, 1'b0, "thresh_wr");
        rd(5'h10, 32'h0000_0004, "thresh_rd");
        wr(5'h00, 32'h5, 4'hF, 1'b0, "ctrl_irq_en");
        rd(5'h00, 32'h0000_0005, "ctrl_irq_rd");
        chk("irq_low_empty", 32'(irq), 32'd0);
        push_run(8'h31, 4);
        repeat (2) @(negedge sys_clk);
        chk("irq_at_thresh", 32'(irq), 32'd1);
        rd(5'h08, 32'h0000_0031, "data_31");
        chk("irq_below_thresh", 32'(irq), 32'd0);
`else
        // Without the threshold feature
        wr(5'h00, 32'h5, 4'hF, 1'b0, "ctrl_irq_en");
        rd(5'h00, 32'h0000_0001, "ctrl_irq_ignored");
        wr(5'h10, 32'h4, 4'hF, 1'b1, "thresh_wr_err");
        rd(5'h10, 32'h0000_0000, "thresh_rd_zero");
        push_run(8'h31, 4);
        repeat (2) @(negedge sys_clk);
        chk("irq_tied_low", 32'(irq), 32'd0);
`endif

        repeat (3) @(negedge sys_clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
